// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the uart transmit scheduler: FSM states, error codes and
// the timeout-counter width helper.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BUSY = 2'b01;
  localparam logic [1:0] ERR_GAP  = 2'b10;

  // One counter serves both watchdogs, so it must hold the larger limit.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// The caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [N-1:0] rot;
  logic [N-1:0] lowest;

  // Rotate right by ptr through a double-width copy, isolate the lowest set
  // bit, then rotate it back left into its original position.
  assign rot    = N'({req, req} >> ptr);
  assign lowest = rot & (~rot + N'(1));
  assign gnt    = N'(({lowest, lowest} << ptr) >> N);
  assign any    = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart transmitter among NUM_REQ requesters, a whole packet at a
// time, with round-robin arbitration and busy/gap watchdogs.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_TIMEOUT  = 256
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         sched_busy,
  output logic                         err_pulse,
  output logic [1:0]                   err_code
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(BUSY_TIMEOUT, GAP_TIMEOUT);
  localparam logic [CW-1:0] BUSY_LIM = CW'(BUSY_TIMEOUT);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_TIMEOUT);

  sched_state_t         state, state_d;
  logic [NUM_REQ-1:0]   grant_d, arb_gnt;
  logic                 arb_any;
  logic [PW-1:0]        ptr, ptr_d, gidx, gnext;
  logic [CW-1:0]        cnt, cnt_d, cnt_inc;
  logic [DATA_BITS-1:0] tx_data_d, gdata;
  logic                 last_q, last_d, tx_send_d, err_pulse_d, accept;
  logic [1:0]           err_code_d;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        gdata = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign gnext      = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
  assign cnt_inc    = (&cnt) ? cnt : cnt + CW'(1);
  assign req_ready  = (state == LOAD) ? (grant & req_valid) : '0;
  assign accept     = |req_ready;
  assign sched_busy = (state != ARB);

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    ptr_d       = ptr;
    cnt_d       = cnt;
    tx_data_d   = tx_data;
    last_d      = last_q;
    tx_send_d   = 1'b0;
    err_pulse_d = 1'b0;
    err_code_d  = err_code;
    case (state)
      ARB: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          tx_data_d = gdata;
          last_d    = |(grant & req_last);
          tx_send_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_BUSY;
        end else if (cnt_inc == GAP_LIM) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_GAP;
          grant_d     = '0;
          ptr_d       = gnext;
          cnt_d       = '0;
          state_d     = ARB;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_inc == BUSY_LIM) begin
          // The byte is dropped; the requester has to resend the packet.
          err_pulse_d = 1'b1;
          err_code_d  = ERR_BUSY;
          grant_d     = '0;
          ptr_d       = gnext;
          cnt_d       = '0;
          state_d     = ARB;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d = '0;
          if (last_q) begin
            grant_d = '0;
            ptr_d   = gnext;
            state_d = ARB;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      grant     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      tx_data   <= '0;
      last_q    <= 1'b0;
      tx_send   <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      tx_data   <= tx_data_d;
      last_q    <= last_d;
      tx_send   <= tx_send_d;
      err_pulse <= err_pulse_d;
      err_code  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a uart stub answers tx_send with a busy frame
// and checks each sent byte and its owner against a scoreboard queue.
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FRAME = 6;

  typedef struct { int idx; logic [7:0] data; bit last; logic [3:0] grant; } vec_t;
  typedef struct { logic [7:0] data; logic [3:0] grant; } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [NR-1:0]    req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    tx_data;
  logic             tx_send, tx_busy, sched_busy, err_pulse;
  logic [1:0]       err_code;

  bit         v_a [NR];
  bit         l_a [NR];
  logic [7:0] d_a [NR];

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   busy_left = 0, last_send_cyc = 0, fall_cyc = 0;
  bit   stub_on = 1'b1;
  int   acc_cyc [NR];
  int   send_log [$];
  exp_t sb [$];
  vec_t vecs [5];

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_BITS(DW), .BUSY_TIMEOUT(16), .GAP_TIMEOUT(256)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .grant(grant), .sched_busy(sched_busy), .err_pulse(err_pulse),
    .err_code(err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = v_a[i];
      req_last[i]           = l_a[i];
      req_data[i*DW +: DW]  = d_a[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // uart stub: busy for FRAME cycles after each tx_send unless disabled
  initial begin
    exp_t e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        busy_left = 0;
        tx_busy   = 1'b0;
      end else begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) fall_cyc = cyc;
        end
        if (tx_send) begin
          last_send_cyc = cyc;
          send_log.push_back(cyc);
          if (sb.size() == 0) fail_now("unexpected_send");
          else begin
            e = sb.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("grant_at_send", grant, e.grant);
          end
          if (stub_on) busy_left = FRAME;
        end
        tx_busy = (busy_left > 0);
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] d, input bit last);
    int n;
    n = 0;
    d_a[i] = d;
    l_a[i] = last;
    v_a[i] = 1'b1;
    #1;
    while (!req_ready[i] && n < 1000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!req_ready[i]) begin
      fail_now($sformatf("accept_timeout_req%0d", i));
      v_a[i] = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    acc_cyc[i] = cyc;
    v_a[i] = 1'b0;
    l_a[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((sb.size() != 0 || sched_busy || tx_busy) && n < 1000);
    if (n >= 1000) fail_now("idle_timeout");
  endtask

  task automatic wait_err(output int c);
    c = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (err_pulse) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_now("err_pulse_timeout");
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ec;
    vecs[0] = '{0, 8'h55, 1'b0, 4'b0001};
    vecs[1] = '{0, 8'hA5, 1'b1, 4'b0001};
    vecs[2] = '{3, 8'hC3, 1'b1, 4'b1000};
    vecs[3] = '{1, 8'h00, 1'b1, 4'b0010};
    vecs[4] = '{2, 8'h5A, 1'b1, 4'b0100};
    for (int i = 0; i < NR; i++) begin
      v_a[i] = 1'b0; l_a[i] = 1'b0; d_a[i] = '0; acc_cyc[i] = 0;
    end

    #1 reset_n = 1'b0;
    #2;
    chk("rst0_grant", grant, 0);
    chk("rst0_sched_busy", sched_busy, 0);
    chk("rst0_tx_send", tx_send, 0);
    chk("rst0_tx_data", tx_data, 0);
    chk("rst0_err", {err_pulse, err_code}, 0);
    chk("rst0_ready", req_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // single-requester packets, including the pointer wrap after req3
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{vecs[k].data, vecs[k].grant});
      send_byte(vecs[k].idx, vecs[k].data, vecs[k].last);
      if (vecs[k].last) begin
        wait_idle();
        chk("grant_idle", grant, 0);
      end
    end

    // req0 two-byte packet races a req2 single byte; req0 wins from ptr=3
    send_log.delete();
    sb.push_back('{8'h11, 4'b0001});
    sb.push_back('{8'h22, 4'b0001});
    sb.push_back('{8'h33, 4'b0100});
    fork
      begin send_byte(0, 8'h11, 1'b0); send_byte(0, 8'h22, 1'b1); end
      send_byte(2, 8'h33, 1'b1);
    join
    wait_idle();
    if (send_log.size() == 3) chk("req2_after_0x22", acc_cyc[2] > send_log[1], 1);
    else fail_now("lock_send_count");

    // all four contending continuously: strict 0,1,2,3 rotation from reset
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        sb.push_back('{8'(8'h40 + 16*i + k), 4'(1 << i)});
    fork
      begin send_byte(0, 8'h40, 1'b1); send_byte(0, 8'h41, 1'b1); end
      begin send_byte(1, 8'h50, 1'b1); send_byte(1, 8'h51, 1'b1); end
      begin send_byte(2, 8'h60, 1'b1); send_byte(2, 8'h61, 1'b1); end
      begin send_byte(3, 8'h70, 1'b1); send_byte(3, 8'h71, 1'b1); end
    join
    wait_idle();

    // uart never busy: error registered 16 cycles after tx_send
    stub_on = 1'b0;
    sb.push_back('{8'h99, 4'b0001});
    send_byte(0, 8'h99, 1'b1);
    wait_err(ec);
    chk("busy_to_err_cycles", ec - last_send_cyc, 16);
    chk("busy_err_code", err_code, 2'b01);
    chk("busy_err_state", {sched_busy, grant}, 0);
    @(negedge clock);
    chk("busy_err_one_cycle", err_pulse, 0);
    stub_on = 1'b1;

    // req1 stalls mid-packet: gap error after 256 idle LOAD cycles, then req2
    sb.push_back('{8'h7E, 4'b0010});
    sb.push_back('{8'h33, 4'b0100});
    send_byte(1, 8'h7E, 1'b0);
    fork
      send_byte(2, 8'h33, 1'b1);
      begin
        wait_err(ec);
        // LOAD starts the cycle after busy falls; pulse follows the 256th cycle
        chk("gap_to_err_cycles", ec - fall_cyc, 257);
        chk("gap_err_code", err_code, 2'b10);
        chk("gap_err_grant", grant, 0);
        @(negedge clock);
        chk("gap_err_one_cycle", err_pulse, 0);
      end
    join
    wait_idle();
    chk("gap_code_held", err_code, 2'b10);

    // reset mid-frame clears every output before the next clock edge
    sb.push_back('{8'hFF, 4'b0001});
    send_byte(0, 8'hFF, 1'b1);
    repeat (3) @(negedge clock);
    chk("midframe_busy", {tx_busy, sched_busy}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_sched_busy", sched_busy, 0);
    chk("rst_tx", {tx_send, tx_data}, 0);
    chk("rst_err", {err_pulse, err_code}, 0);
    chk("rst_ready", req_ready, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.push_back('{8'h3C, 4'b1000});
    send_byte(3, 8'h3C, 1'b1);
    wait_idle();
    chk("post_rst_grant_idle", grant, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
